// File: rtl/eth_phy_wdg_pkg.sv
// Shared constants, lane state encoding and counter helpers for the
// multi-lane 10GBASE-R RX watchdog.
package eth_phy_wdg_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_UP      = 2'd1,
        ST_HOLDOFF = 2'd2
    } lane_state_t;

    localparam int CNT_W     = 8;
    localparam int BLK_ERR_W = 10;

    localparam logic [CNT_W-1:0]     CNT_MAX     = '1;
    localparam logic [BLK_ERR_W-1:0] BLK_ERR_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_watchdog_mc_if.sv
// Lane-side inputs and reset-controller-side outputs of the RX watchdog.
interface eth_phy_10g_rx_watchdog_mc_if #(
    parameter int LANES = 4
);
    logic [LANES-1:0]   lane_en;
    logic [2*LANES-1:0] serdes_rx_hdr;
    logic [LANES-1:0]   rx_bad_block;
    logic [LANES-1:0]   rx_sequence_error;
    logic [LANES-1:0]   rx_block_lock;
    logic [LANES-1:0]   rx_high_ber;
    logic [LANES-1:0]   serdes_rx_reset_req;
    logic [LANES-1:0]   rx_status;
    logic               rx_status_all;
    logic [8*LANES-1:0] reset_req_count;

    modport master (
        output lane_en, serdes_rx_hdr, rx_bad_block, rx_sequence_error,
               rx_block_lock, rx_high_ber,
        input  serdes_rx_reset_req, rx_status, rx_status_all, reset_req_count
    );

    modport slave (
        input  lane_en, serdes_rx_hdr, rx_bad_block, rx_sequence_error,
               rx_block_lock, rx_high_ber,
        output serdes_rx_reset_req, rx_status, rx_status_all, reset_req_count
    );
endinterface

// File: rtl/eth_phy_10g_rx_watchdog_lane.sv
// One supervised lane: window accumulators, INIT/UP/HOLDOFF FSM, window
// counters and the saturating reset-request counter.
module eth_phy_10g_rx_watchdog_lane
    import eth_phy_wdg_pkg::*;
#(
    parameter int ERR_WINDOWS     = 16,
    parameter int STATUS_WINDOWS  = 16,
    parameter int BLK_ERR_LIMIT   = 1023,
    parameter int HOLDOFF_WINDOWS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             en,
    input  logic [1:0]       hdr,
    input  logic             bad_block,
    input  logic             seq_err,
    input  logic             block_lock,
    input  logic             high_ber,
    output logic             req,
    output logic             status,
    output logic             status_nxt,
    output logic [CNT_W-1:0] req_count
);
    localparam logic [CNT_W-1:0]     ERR_LAST    = CNT_W'(ERR_WINDOWS - 1);
    localparam logic [CNT_W-1:0]     STATUS_LAST = CNT_W'(STATUS_WINDOWS - 1);
    localparam logic [CNT_W-1:0]     HOLD_INIT   = CNT_W'(HOLDOFF_WINDOWS);
    localparam logic [BLK_ERR_W-1:0] BLK_LIM     = BLK_ERR_W'(BLK_ERR_LIMIT);

    lane_state_t          state, state_nxt;
    logic [CNT_W-1:0]     err_cnt, err_nxt, good_cnt, good_nxt;
    logic [CNT_W-1:0]     hold_cnt, hold_nxt, rcnt_nxt;
    logic                 req_nxt, saw_ctrl, win_bad;
    logic [BLK_ERR_W-1:0] blk_err;

    // Tick-cycle inputs are dropped: the tick both judges and restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saw_ctrl <= 1'b0;
            blk_err  <= '0;
        end else if (!en || tick) begin
            saw_ctrl <= 1'b0;
            blk_err  <= '0;
        end else begin
            if (block_lock && hdr == SYNC_CTRL)
                saw_ctrl <= 1'b1;
            if (block_lock && (bad_block || seq_err) && blk_err != BLK_ERR_MAX)
                blk_err <= blk_err + BLK_ERR_W'(1);
        end
    end

    assign win_bad = !saw_ctrl || (blk_err >= BLK_LIM) || high_ber;

    always_comb begin
        state_nxt = state;
        err_nxt   = err_cnt;
        good_nxt  = good_cnt;
        hold_nxt  = hold_cnt;
        rcnt_nxt  = req_count;
        req_nxt   = 1'b0;
        if (!en) begin
            state_nxt = ST_INIT;
            err_nxt   = '0;
            good_nxt  = '0;
            hold_nxt  = '0;
        end else begin
            case (state)
                ST_INIT, ST_UP: begin
                    if (state == ST_UP && !block_lock) begin
                        state_nxt = ST_INIT;
                        err_nxt   = '0;
                        good_nxt  = '0;
                    end else if (tick) begin
                        if (win_bad) begin
                            good_nxt = '0;
                            if (err_cnt == ERR_LAST) begin
                                req_nxt  = 1'b1;
                                err_nxt  = '0;
                                rcnt_nxt = sat_inc(req_count);
                                if (HOLDOFF_WINDOWS == 0) begin
                                    state_nxt = ST_INIT;
                                end else begin
                                    state_nxt = ST_HOLDOFF;
                                    hold_nxt  = HOLD_INIT;
                                end
                            end else begin
                                err_nxt = sat_inc(err_cnt);
                            end
                        end else begin
                            err_nxt = '0;
                            if (state == ST_INIT) begin
                                if (good_cnt == STATUS_LAST) begin
                                    state_nxt = ST_UP;
                                    good_nxt  = '0;
                                end else begin
                                    good_nxt = sat_inc(good_cnt);
                                end
                            end
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (tick) begin
                        if (hold_cnt <= CNT_W'(1)) begin
                            state_nxt = ST_INIT;
                            hold_nxt  = '0;
                        end else begin
                            hold_nxt = hold_cnt - CNT_W'(1);
                        end
                    end
                end
                default: state_nxt = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            err_cnt   <= '0;
            good_cnt  <= '0;
            hold_cnt  <= '0;
            req_count <= '0;
            req       <= 1'b0;
        end else begin
            state     <= state_nxt;
            err_cnt   <= err_nxt;
            good_cnt  <= good_nxt;
            hold_cnt  <= hold_nxt;
            req_count <= rcnt_nxt;
            req       <= req_nxt;
        end
    end

    assign status     = (state == ST_UP);
    assign status_nxt = (state_nxt == ST_UP);

endmodule

// File: rtl/eth_phy_10g_rx_watchdog_mc.sv
// Multi-lane RX watchdog top: shared 125 us window timer, LANES lane
// supervisors and the registered all-enabled-lanes-good reduction.
module eth_phy_10g_rx_watchdog_mc
    import eth_phy_wdg_pkg::*;
#(
    parameter int LANES           = 4,
    parameter int HDR_WIDTH       = 2,
    parameter int COUNT_125US     = 19531,
    parameter int ERR_WINDOWS     = 16,
    parameter int STATUS_WINDOWS  = 16,
    parameter int BLK_ERR_LIMIT   = 1023,
    parameter int HOLDOFF_WINDOWS = 4
) (
    input logic                         clk,
    input logic                         rst_n,
    eth_phy_10g_rx_watchdog_mc_if.slave bus
);
    localparam int TMR_W = (COUNT_125US > 1) ? $clog2(COUNT_125US) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(COUNT_125US - 1);

    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
        $error("eth_phy_10g_rx_watchdog_mc: HDR_WIDTH must be 2");
    end

    logic [TMR_W-1:0] timer;
    logic             tick;
    logic [LANES-1:0] status_nxt;

    assign tick = (timer == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    timer <= TMR_RELOAD;
        else if (tick) timer <= TMR_RELOAD;
        else           timer <= timer - TMR_W'(1);
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        eth_phy_10g_rx_watchdog_lane #(
            .ERR_WINDOWS    (ERR_WINDOWS),
            .STATUS_WINDOWS (STATUS_WINDOWS),
            .BLK_ERR_LIMIT  (BLK_ERR_LIMIT),
            .HOLDOFF_WINDOWS(HOLDOFF_WINDOWS)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .en        (bus.lane_en[i]),
            .hdr       (bus.serdes_rx_hdr[2*i +: 2]),
            .bad_block (bus.rx_bad_block[i]),
            .seq_err   (bus.rx_sequence_error[i]),
            .block_lock(bus.rx_block_lock[i]),
            .high_ber  (bus.rx_high_ber[i]),
            .req       (bus.serdes_rx_reset_req[i]),
            .status    (bus.rx_status[i]),
            .status_nxt(status_nxt[i]),
            .req_count (bus.reset_req_count[8*i +: 8])
        );
    end

    // Disabled lanes are masked out; no enabled lane at all means not good.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.rx_status_all <= 1'b0;
        else        bus.rx_status_all <= (|bus.lane_en) && (&(status_nxt | ~bus.lane_en));
    end

endmodule

// File: tb/tb_eth_phy_10g_rx_watchdog_mc.sv
// Randomized and directed bench for the multi-lane RX watchdog with a
// window-level behavioural model and literal pins on key events.
module tb_eth_phy_10g_rx_watchdog_mc;
    import eth_phy_wdg_pkg::*;

    localparam int LANES  = 4;
    localparam int COUNT  = 16;
    localparam int ERRW   = 4;
    localparam int STATW  = 3;
    localparam int HOLDW  = 2;
    localparam int BLKLIM = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_phy_10g_rx_watchdog_mc_if #(.LANES(LANES)) bus();

    eth_phy_10g_rx_watchdog_mc #(
        .LANES(LANES), .HDR_WIDTH(2), .COUNT_125US(COUNT), .ERR_WINDOWS(ERRW),
        .STATUS_WINDOWS(STATW), .BLK_ERR_LIMIT(BLKLIM), .HOLDOFF_WINDOWS(HOLDW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // model: window-level view of each lane
    int n;
    int m_up[LANES], m_bad[LANES], m_good[LANES], m_hold[LANES];
    int m_saw[LANES], m_errs[LANES], m_cnt[LANES], e_req[LANES];
    int e_all;

    // stimulus knobs
    logic [3:0] en_knob, idle, nctrl;
    int bb0, drop_lane, drop_n;
    bit rnd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        e_all = 0;
        for (int i = 0; i < LANES; i++) begin
            m_up[i] = 0; m_bad[i] = 0; m_good[i] = 0; m_hold[i] = 0;
            m_saw[i] = 0; m_errs[i] = 0; m_cnt[i] = 0; e_req[i] = 0;
        end
    endtask

    task automatic gen_inputs();
        int nn = n + 1;
        int pos = nn % COUNT;
        logic [7:0] hdr = '0;
        logic [3:0] bb = '0, se = '0, lk = '0, hb = '0;
        for (int i = 0; i < LANES; i++) begin
            if (rnd) begin
                if ($urandom_range(99) == 0) en_knob[i] = ~en_knob[i];
                lk[i] = ($urandom_range(99) < 97);
                hdr[2*i +: 2] = ($urandom_range(3) == 0) ? SYNC_CTRL : 2'($urandom_range(3));
                bb[i] = ($urandom_range(99) < 8);
                se[i] = ($urandom_range(99) < 4);
                hb[i] = ($urandom_range(99) < 5);
            end else begin
                lk[i] = !idle[i] && !(i == drop_lane && nn == drop_n);
                hdr[2*i +: 2] = idle[i] ? 2'b00 :
                                (nctrl[i] || (nn % 8) != 3) ? SYNC_DATA : SYNC_CTRL;
                bb[i] = (i == 0) && pos >= 1 && pos <= bb0;
            end
        end
        bus.lane_en           = en_knob;
        bus.serdes_rx_hdr     = hdr;
        bus.rx_bad_block      = bb;
        bus.rx_sequence_error = se;
        bus.rx_block_lock     = lk;
        bus.rx_high_ber       = hb;
    endtask

    // Predict the outputs after the coming clock edge from the current inputs.
    task automatic model_update();
        int tick, wb, any_en, all_ok;
        n++;
        tick = ((n % COUNT) == 0);
        any_en = 0;
        all_ok = 1;
        for (int i = 0; i < LANES; i++) begin
            e_req[i] = 0;
            if (!bus.lane_en[i]) begin
                m_up[i] = 0; m_bad[i] = 0; m_good[i] = 0; m_hold[i] = 0;
                m_saw[i] = 0; m_errs[i] = 0;
            end else begin
                wb = (m_saw[i] == 0 || m_errs[i] >= BLKLIM || bus.rx_high_ber[i]) ? 1 : 0;
                if (m_hold[i] > 0) begin
                    if (tick) m_hold[i]--;
                end else if (m_up[i] && !bus.rx_block_lock[i]) begin
                    m_up[i] = 0; m_bad[i] = 0; m_good[i] = 0;
                end else if (tick) begin
                    if (wb) begin
                        m_good[i] = 0;
                        m_bad[i]++;
                        if (m_bad[i] == ERRW) begin
                            e_req[i] = 1; m_bad[i] = 0; m_up[i] = 0; m_hold[i] = HOLDW;
                            if (m_cnt[i] < 255) m_cnt[i]++;
                        end
                    end else begin
                        m_bad[i] = 0;
                        if (!m_up[i]) begin
                            m_good[i]++;
                            if (m_good[i] == STATW) begin m_up[i] = 1; m_good[i] = 0; end
                        end
                    end
                end
                if (tick) begin
                    m_saw[i] = 0; m_errs[i] = 0;
                end else begin
                    if (bus.rx_block_lock[i] && bus.serdes_rx_hdr[2*i +: 2] == SYNC_CTRL) m_saw[i] = 1;
                    if (bus.rx_block_lock[i] && (bus.rx_bad_block[i] || bus.rx_sequence_error[i])
                        && m_errs[i] < 1023) m_errs[i]++;
                end
            end
            if (bus.lane_en[i]) begin
                any_en = 1;
                if (!m_up[i]) all_ok = 0;
            end
        end
        e_all = any_en && all_ok;
    endtask

    task automatic compare();
        logic [3:0]  xr, xs;
        logic [31:0] xc;
        for (int i = 0; i < LANES; i++) begin
            xr[i] = e_req[i][0];
            xs[i] = m_up[i][0];
            xc[8*i +: 8] = 8'(m_cnt[i]);
        end
        check("req", 32'(bus.serdes_rx_reset_req), 32'(xr));
        check("status", 32'(bus.rx_status), 32'(xs));
        check("status_all", 32'(bus.rx_status_all), 32'(e_all[0]));
        check("req_count", bus.reset_req_count, xc);
    endtask

    task automatic step();
        gen_inputs();
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic run_until(input int target);
        while (n < target) step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"}, 32'(bus.serdes_rx_reset_req), 32'h0);
        check({tag, "_status"}, 32'(bus.rx_status), 32'h0);
        check({tag, "_all"}, 32'(bus.rx_status_all), 32'h0);
        check({tag, "_count"}, bus.reset_req_count, 32'h0);
    endtask

    task automatic pulse_reset();
        #3 rst_n = 1'b0;
        #1 check_zero("rst_async");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        en_knob = 4'hF; idle = '0; nctrl = '0; bb0 = 0;
        drop_lane = -1; drop_n = -1; rnd = 0;
        bus.lane_en = '0; bus.serdes_rx_hdr = '0; bus.rx_bad_block = '0;
        bus.rx_sequence_error = '0; bus.rx_block_lock = '0; bus.rx_high_ber = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_zero("rst_init");
        rst_n = 1'b1;

        // clean lanes qualify on the 3rd tick
        run_until(47);
        check("pin_status_pre", 32'(bus.rx_status), 32'h0);
        run_until(48);
        check("pin_status_up", 32'(bus.rx_status), 32'hF);
        check("pin_all_up", 32'(bus.rx_status_all), 32'h1);

        // lane 2 without CTRL headers: request after 4 bad windows, then holdoff
        nctrl = 4'b0100;
        run_until(111);
        check("pin_req2_pre", 32'(bus.serdes_rx_reset_req), 32'h0);
        run_until(112);
        check("pin_req2", 32'(bus.serdes_rx_reset_req), 32'h4);
        check("pin_cnt2", 32'(bus.reset_req_count[23:16]), 32'h1);
        nctrl = '0;
        run_until(191);
        check("pin_status2_hold", 32'(bus.rx_status[2]), 32'h0);
        run_until(192);
        check("pin_status2_back", 32'(bus.rx_status), 32'hF);

        // lane 1 lock drop mid-window
        drop_lane = 1; drop_n = 200;
        run_until(200);
        check("pin_lockloss", 32'(bus.rx_status), 32'hD);
        run_until(239);
        check("pin_relock_pre", 32'(bus.rx_status[1]), 32'h0);
        run_until(240);
        check("pin_relock", 32'(bus.rx_status), 32'hF);
        drop_lane = -1;

        // block-error limit on lane 0: 5 per window bad, 4 per window good
        bb0 = 5;
        run_until(304);
        check("pin_req0", 32'(bus.serdes_rx_reset_req), 32'h1);
        check("pin_cnt0", 32'(bus.reset_req_count[7:0]), 32'h1);
        bb0 = 4;
        run_until(384);
        check("pin_blk4_up", 32'(bus.rx_status), 32'hF);

        // lane 3 masked, lane 0 drops enable on the tick of its 4th bad window
        bb0 = 0; en_knob = 4'b0111; idle = 4'b1000; nctrl = 4'b0001;
        run_until(447);
        check("pin_all_masked", 32'(bus.rx_status_all), 32'h1);
        en_knob = 4'b0110;
        run_until(448);
        check("pin_en_tick_req", 32'(bus.serdes_rx_reset_req), 32'h0);
        check("pin_en_tick_status", 32'(bus.rx_status), 32'h6);
        check("pin_en_tick_cnt", 32'(bus.reset_req_count[7:0]), 32'h1);

        // all lanes fail into holdoff, then reset mid-window
        en_knob = 4'hF; idle = '0; nctrl = 4'hF;
        run_until(512);
        check("pin_req_all", 32'(bus.serdes_rx_reset_req), 32'hF);
        run_until(520);
        pulse_reset();
        nctrl = '0;
        run_until(47);
        check("pin_post_rst_pre", 32'(bus.rx_status), 32'h0);
        run_until(48);
        check("pin_post_rst_up", 32'(bus.rx_status), 32'hF);

        // random traffic
        rnd = 1;
        for (int k = 0; k < 2500; k++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
